// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit that feeds the register-file write port.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    WB     = 2'd3
  } lsu_state_t;

  // Wide enough to hold MEM_LAT-2 for the largest legal latency of 8.
  localparam int LAT_CW = 3;

endpackage

// File: rtl/lsu_wb_if.sv
// Command, data-memory and register-file write bundle of the load/store unit.
// The slave modport is the LSU's view; the master modport is control, memory and register file.
interface lsu_wb_if #(
  parameter int W = 8,
  parameter int D = 4,
  parameter int A = 8
);
  logic         start;
  logic         is_store;
  logic [D-1:0] rd;
  logic [W-1:0] addr_in;
  logic [W-1:0] st_data;
  logic         busy;
  logic         done;
  logic [A-1:0] mem_addr;
  logic         mem_ren;
  logic         mem_wen;
  logic [W-1:0] mem_wdata;
  logic [W-1:0] mem_rdata;
  logic         rf_write_en;
  logic [D-1:0] rf_waddr;
  logic [W-1:0] rf_data;

  modport master (
    output start, is_store, rd, addr_in, st_data, mem_rdata,
    input  busy, done, mem_addr, mem_ren, mem_wen, mem_wdata,
           rf_write_en, rf_waddr, rf_data
  );

  modport slave (
    input  start, is_store, rd, addr_in, st_data, mem_rdata,
    output busy, done, mem_addr, mem_ren, mem_wen, mem_wdata,
           rf_write_en, rf_waddr, rf_data
  );
endinterface

// File: rtl/lsu_sat_ctr.sv
// 16-bit event counter that sticks at 16'hFFFF instead of wrapping.
module lsu_sat_ctr (
  input  logic        clk,
  input  logic        reset,
  input  logic        inc_i,
  output logic [15:0] cnt_o
);
  logic [15:0] cnt_q;
  logic [15:0] cnt_d;

  assign cnt_d = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (inc_i) begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
endmodule

// File: rtl/lsu_wb.sv
// Load/store unit: drives the single-port data memory and produces the register-file write triple.
// Optional load/store completion counters are built when LSU_STAT_EN is defined.
module lsu_wb
  import lsu_pkg::*;
#(
  parameter int W       = 8,
  parameter int D       = 4,
  parameter int A       = 8,
  parameter int MEM_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  lsu_wb_if.slave     bus
`ifdef LSU_STAT_EN
  ,
  output logic [15:0] ld_cnt,
  output logic [15:0] st_cnt
`endif
);
  localparam logic [LAT_CW-1:0] WAIT_INIT = LAT_CW'((MEM_LAT > 1) ? MEM_LAT - 2 : 0);

  lsu_state_t        state_q;
  logic [LAT_CW-1:0] cnt_q;
  logic              is_store_q;
  logic [D-1:0]      rd_q;
  logic [A-1:0]      addr_q;
  logic [W-1:0]      wdata_q;
  logic              busy_q;
  logic              done_q;
  logic              ren_q;
  logic              wen_q;
  logic              rf_we_q;

  // Strobes are decided one state ahead so every output comes straight from a flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      is_store_q <= 1'b0;
      rd_q       <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ren_q      <= 1'b0;
      wen_q      <= 1'b0;
      rf_we_q    <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      ren_q   <= 1'b0;
      wen_q   <= 1'b0;
      rf_we_q <= 1'b0;
      wdata_q <= '0;
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_q    <= ACCESS;
            busy_q     <= 1'b1;
            is_store_q <= bus.is_store;
            rd_q       <= bus.rd;
            addr_q     <= A'(bus.addr_in);
            if (bus.is_store) begin
              wen_q   <= 1'b1;
              wdata_q <= bus.st_data;
              done_q  <= 1'b1;
            end else begin
              ren_q <= 1'b1;
            end
          end
        end
        ACCESS: begin
          if (is_store_q) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else if (MEM_LAT == 1) begin
            state_q <= WB;
            rf_we_q <= 1'b1;
            done_q  <= 1'b1;
          end else begin
            state_q <= WAIT;
            cnt_q   <= WAIT_INIT;
          end
        end
        WAIT: begin
          if (cnt_q == '0) begin
            state_q <= WB;
            rf_we_q <= 1'b1;
            done_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        WB: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.mem_addr    = addr_q;
  assign bus.mem_ren     = ren_q;
  assign bus.mem_wen     = wen_q;
  assign bus.mem_wdata   = wdata_q;
  assign bus.rf_write_en = rf_we_q;
  assign bus.rf_waddr    = rd_q;
  // Read data passes straight through during WB so the register file captures it at the WB edge.
  assign bus.rf_data     = rf_we_q ? bus.mem_rdata : '0;

`ifdef LSU_STAT_EN
  lsu_sat_ctr u_ld_ctr (
    .clk   (clk),
    .reset (reset),
    .inc_i (done_q & ~is_store_q),
    .cnt_o (ld_cnt)
  );

  lsu_sat_ctr u_st_ctr (
    .clk   (clk),
    .reset (reset),
    .inc_i (done_q & is_store_q),
    .cnt_o (st_cnt)
  );
`endif
endmodule

// File: tb/tb_lsu_wb.sv
// Self-checking bench for lsu_wb: three lanes with MEM_LAT = 1, 2, 3, each with its own memory model.
// Build with LSU_STAT_EN defined to also exercise the load/store counters.
module tb_lsu_wb;
  localparam int NL = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [NL-1:0]       start_v = '0;
  logic [NL-1:0]       is_store_v = '0;
  logic [NL-1:0][3:0]  rd_v = '0;
  logic [NL-1:0][7:0]  addr_v = '0;
  logic [NL-1:0][7:0]  st_v = '0;
  logic [NL-1:0]       busy_v, done_v, ren_v, wen_v, we_v;
  logic [NL-1:0][7:0]  maddr_v, wdata_v, rfdata_v, rdata_v;
  logic [NL-1:0][3:0]  waddr_v;
`ifdef LSU_STAT_EN
  logic [NL-1:0][15:0] ldc_v, stc_v;
`endif

  int total = 0;
  int bad = 0;

  // Memory content the bench expects: written only by the stores it issues.
  logic [7:0] ref_mem [NL][256];
  bit         ref_w   [NL][256];
  int         exp_ld  [NL];
  int         exp_st  [NL];

  // Memory model driven by the DUT strobes.
  logic [7:0] mem_m [NL][256];
  bit         mem_w [NL][256];
  logic [7:0] rpipe [NL][8];

  function automatic logic [7:0] init_byte(input int ln, input logic [7:0] a);
    return a ^ 8'h5A ^ 8'(ln * 17);
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < NL; gi++) begin : g_lane
      lsu_wb_if #(.W(8), .D(4), .A(8)) ifc ();
      assign ifc.start     = start_v[gi];
      assign ifc.is_store  = is_store_v[gi];
      assign ifc.rd        = rd_v[gi];
      assign ifc.addr_in   = addr_v[gi];
      assign ifc.st_data   = st_v[gi];
      assign ifc.mem_rdata = rdata_v[gi];
      assign busy_v[gi]    = ifc.busy;
      assign done_v[gi]    = ifc.done;
      assign ren_v[gi]     = ifc.mem_ren;
      assign wen_v[gi]     = ifc.mem_wen;
      assign we_v[gi]      = ifc.rf_write_en;
      assign maddr_v[gi]   = ifc.mem_addr;
      assign wdata_v[gi]   = ifc.mem_wdata;
      assign rfdata_v[gi]  = ifc.rf_data;
      assign waddr_v[gi]   = ifc.rf_waddr;
      assign rdata_v[gi]   = rpipe[gi][gi];

      lsu_wb #(.W(8), .D(4), .A(8), .MEM_LAT(gi + 1)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc)
`ifdef LSU_STAT_EN
        ,
        .ld_cnt (ldc_v[gi]),
        .st_cnt (stc_v[gi])
`endif
      );
    end
  endgenerate

  always @(posedge clk) begin
    for (int g = 0; g < NL; g++) begin
      if (wen_v[g]) begin
        mem_m[g][maddr_v[g]] <= wdata_v[g];
        mem_w[g][maddr_v[g]] <= 1'b1;
      end
      for (int i = 7; i > 0; i--) rpipe[g][i] <= rpipe[g][i-1];
      if (ren_v[g])
        rpipe[g][0] <= mem_w[g][maddr_v[g]] ? mem_m[g][maddr_v[g]] : init_byte(g, maddr_v[g]);
      else
        rpipe[g][0] <= 8'h00;
    end
  end

  // One command on one lane, checked cycle by cycle; ends in the idle cycle after done.
  task automatic do_op(input int ln, input bit st, input logic [3:0] rd,
                       input logic [7:0] addr, input logic [7:0] data, input bit hold);
    int lat;
    logic [7:0] exp_d;
    logic [4:0] got_s, exp_s;
    lat   = st ? 1 : 2 + ln;
    exp_d = ref_w[ln][addr] ? ref_mem[ln][addr] : init_byte(ln, addr);
    $display("op lane=%0d lat=%0d %s rd=%0d addr=%h data=%h hold=%0d",
             ln, ln + 1, st ? "store" : "load", rd, addr, st ? data : exp_d, hold);
    start_v[ln] = 1'b1; is_store_v[ln] = st; rd_v[ln] = rd; addr_v[ln] = addr; st_v[ln] = data;
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      if (hold) begin
        is_store_v[ln] = 1'($urandom); rd_v[ln] = 4'($urandom);
        addr_v[ln] = 8'($urandom); st_v[ln] = 8'($urandom);
      end else begin
        start_v[ln] = 1'b0;
      end
      got_s = {busy_v[ln], done_v[ln], ren_v[ln], wen_v[ln], we_v[ln]};
      exp_s = {1'b1, k == lat, !st && k == 1, st && k == 1, !st && k == lat};
      total++;
      if (got_s !== exp_s) begin
        bad++;
        $display("FAIL strobes lane=%0d cyc=%0d got=%b exp=%b (busy,done,ren,wen,rfwe)", ln, k, got_s, exp_s);
      end
      total++;
      if (maddr_v[ln] !== addr) begin
        bad++;
        $display("FAIL mem_addr lane=%0d cyc=%0d got=%h exp=%h", ln, k, maddr_v[ln], addr);
      end
      if (st) begin
        total++;
        if (wdata_v[ln] !== data) begin
          bad++;
          $display("FAIL mem_wdata lane=%0d got=%h exp=%h", ln, wdata_v[ln], data);
        end
      end else if (k == lat) begin
        total++;
        if (waddr_v[ln] !== rd || rfdata_v[ln] !== exp_d) begin
          bad++;
          $display("FAIL rf_write lane=%0d got=%0d/%h exp=%0d/%h", ln, waddr_v[ln], rfdata_v[ln], rd, exp_d);
        end
      end else if (k > 1) begin
        total++;
        if (wdata_v[ln] !== 8'h00 || rfdata_v[ln] !== 8'h00) begin
          bad++;
          $display("FAIL quiet_wait lane=%0d cyc=%0d got=%h/%h exp=00/00", ln, k, wdata_v[ln], rfdata_v[ln]);
        end
      end
    end
    @(negedge clk);
    start_v[ln] = 1'b0;
    got_s = {busy_v[ln], done_v[ln], ren_v[ln], wen_v[ln], we_v[ln]};
    total++;
    if (got_s !== 5'b0 || rfdata_v[ln] !== 8'h00 || wdata_v[ln] !== 8'h00) begin
      bad++;
      $display("FAIL after_done lane=%0d got=%b/%h/%h exp=00000/00/00", ln, got_s, rfdata_v[ln], wdata_v[ln]);
    end
    if (st) begin
      ref_mem[ln][addr] = data;
      ref_w[ln][addr]   = 1'b1;
      if (exp_st[ln] < 65535) exp_st[ln]++;
    end else if (exp_ld[ln] < 65535) begin
      exp_ld[ln]++;
    end
  endtask

  task automatic check_idle_all(input string tag);
    for (int ln = 0; ln < NL; ln++) begin
      total++;
      if ({busy_v[ln], done_v[ln], ren_v[ln], wen_v[ln], we_v[ln]} !== 5'b0) begin
        bad++;
        $display("FAIL %s_strobes lane=%0d got=%b exp=00000", tag, ln,
                 {busy_v[ln], done_v[ln], ren_v[ln], wen_v[ln], we_v[ln]});
      end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int ln = 0; ln < NL; ln++) begin exp_ld[ln] = 0; exp_st[ln] = 0; end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check_idle_all("reset");
      for (int ln = 0; ln < NL; ln++) begin
        total++;
        if (maddr_v[ln] !== 8'h00 || wdata_v[ln] !== 8'h00 || waddr_v[ln] !== 4'h0 || rfdata_v[ln] !== 8'h00) begin
          bad++;
          $display("FAIL reset_buses lane=%0d got=%h/%h/%h/%h exp=00/00/0/00", ln,
                   maddr_v[ln], wdata_v[ln], waddr_v[ln], rfdata_v[ln]);
        end
      end
    end
    $display("reset checked for 3 idle cycles");
  endtask

  task automatic test_directed();
    do_op(0, 1'b1, 4'd0, 8'h20, 8'hA5, 1'b0);
    do_op(2, 1'b1, 4'd0, 8'h20, 8'hA5, 1'b0);
    do_op(2, 1'b0, 4'd5, 8'h20, 8'h00, 1'b0);
    do_op(0, 1'b0, 4'd0, 8'h20, 8'h00, 1'b0);
    do_op(1, 1'b1, 4'd0, 8'hFF, 8'h3C, 1'b0);
    do_op(1, 1'b0, 4'd0, 8'hFF, 8'h00, 1'b0);
  endtask

  task automatic test_ignore_start();
    do_op(1, 1'b0, 4'd9, 8'h20, 8'h00, 1'b1);
    do_op(1, 1'b1, 4'd0, 8'h21, 8'h77, 1'b1);
    do_op(1, 1'b1, 4'd0, 8'h22, 8'h88, 1'b0);
    do_op(1, 1'b0, 4'd3, 8'h21, 8'h00, 1'b0);
  endtask

  task automatic test_reset_mid();
    start_v[2] = 1'b1; is_store_v[2] = 1'b0; rd_v[2] = 4'd7; addr_v[2] = 8'h33;
    @(negedge clk);
    start_v[2] = 1'b0;
    total++;
    if (ren_v[2] !== 1'b1) begin bad++; $display("FAIL rstmid_access got=%b exp=1", ren_v[2]); end
    @(negedge clk);
    total++;
    if ({busy_v[2], done_v[2], ren_v[2], wen_v[2], we_v[2]} !== 5'b10000) begin
      bad++;
      $display("FAIL rstmid_wait got=%b exp=10000", {busy_v[2], done_v[2], ren_v[2], wen_v[2], we_v[2]});
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int ln = 0; ln < NL; ln++) begin exp_ld[ln] = 0; exp_st[ln] = 0; end
    for (int c = 0; c < 4; c++) begin
      check_idle_all("rstmid");
      @(negedge clk);
    end
    $display("reset during load wait checked");
    start_v[0] = 1'b1; is_store_v[0] = 1'b1; addr_v[0] = 8'h44; st_v[0] = 8'hEE; reset = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0; reset = 1'b0;
    check_idle_all("rststore");
    @(negedge clk);
    check_idle_all("rststore2");
    $display("store dropped by reset checked");
    do_op(2, 1'b0, 4'd7, 8'h33, 8'h00, 1'b0);
    do_op(0, 1'b0, 4'd1, 8'h44, 8'h00, 1'b0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 45; n++) begin
      int ln, r;
      logic [7:0] a;
      ln = $urandom_range(0, NL - 1);
      r  = $urandom_range(0, 9);
      a  = (r == 0) ? 8'hFF : (r == 1) ? 8'h00 : {5'b01000, 3'($urandom_range(0, 7))};
      do_op(ln, 1'($urandom_range(0, 1)), 4'($urandom), a, 8'($urandom), $urandom_range(0, 3) == 0);
    end
  endtask

`ifdef LSU_STAT_EN
  task automatic test_stats();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int ln = 0; ln < NL; ln++) begin exp_ld[ln] = 0; exp_st[ln] = 0; end
    do_op(1, 1'b0, 4'd1, 8'h10, 8'h00, 1'b0);
    do_op(1, 1'b1, 4'd0, 8'h11, 8'h12, 1'b0);
    do_op(1, 1'b1, 4'd0, 8'h12, 8'h34, 1'b0);
    do_op(1, 1'b0, 4'd2, 8'h11, 8'h00, 1'b0);
    do_op(1, 1'b1, 4'd0, 8'h13, 8'h56, 1'b0);
    for (int ln = 0; ln < NL; ln++) begin
      total++;
      if (ldc_v[ln] !== 16'(exp_ld[ln]) || stc_v[ln] !== 16'(exp_st[ln])) begin
        bad++;
        $display("FAIL stat_cnt lane=%0d got=%0d/%0d exp=%0d/%0d", ln, ldc_v[ln], stc_v[ln], exp_ld[ln], exp_st[ln]);
      end
    end
    force g_lane[1].u_dut.u_st_ctr.cnt_q = 16'hFFFF;
    @(negedge clk);
    release g_lane[1].u_dut.u_st_ctr.cnt_q;
    exp_st[1] = 65535;
    do_op(1, 1'b1, 4'd0, 8'h14, 8'h9A, 1'b0);
    total++;
    if (stc_v[1] !== 16'hFFFF || ldc_v[1] !== 16'd2) begin
      bad++;
      $display("FAIL stat_sat got=%h/%0d exp=ffff/2", stc_v[1], ldc_v[1]);
    end
    $display("stat counters checked");
  endtask
`endif

  initial begin
    test_reset();
    test_directed();
    test_ignore_start();
    test_reset_mid();
    test_random();
`ifdef LSU_STAT_EN
    test_stats();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/lsu_wb.md
Name: lsu_wb

Overview:
- Load/store unit that sits directly upstream of the register file write port.
- Takes a load/store command from control, with the address from register-file port B and store data from port A (the accumulator, r0).
- Drives the single-port data memory.
- For loads, produces the register-file write triple (write_en, waddr, data_in). The register file consumes it at the next clock edge.

Parameters:
- W, 8, datapath width (matches register-file data width)
- D, 4, register address width (2**D registers)
- A, 8, data-memory address width; the low A bits of addr_in are used (zero-extended if A > W)
- MEM_LAT, 1, data-memory read latency in cycles, legal range 1..8

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  command strobe, sampled only in IDLE
- is_store  in  1  1 = store, 0 = load; sampled with start
- rd  in  D  load destination register; sampled with start
- addr_in  in  W  memory address (register-file data_outB); sampled with start
- st_data  in  W  store data (register-file data_outA); sampled with start
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle completion pulse
- mem_addr  out  A  memory address
- mem_ren  out  1  memory read strobe
- mem_wen  out  1  memory write strobe
- mem_wdata  out  W  memory write data
- mem_rdata  in  W  memory read data, valid MEM_LAT cycles after the mem_ren cycle
- rf_write_en  out  1  register-file write enable
- rf_waddr  out  D  register-file write address
- rf_data  out  W  register-file write data

Behaviour:
- Clock is clk. Reset is reset: one clock, synchronous, active-high. These are fixed.
- Reset values:
  - state = IDLE.
  - busy, done, mem_ren, mem_wen, rf_write_en = 0.
  - Captured addr/data/rd registers = 0, so mem_addr, mem_wdata, rf_waddr = 0.
- FSM states: IDLE, ACCESS, WAIT, WB.
- IDLE:
  - If start=1 at edge T, capture is_store, rd, addr_in[A-1:0], st_data, then go to ACCESS.
  - Otherwise stay in IDLE.
- ACCESS (cycle T+1):
  - mem_addr = captured address.
  - Store: mem_wen=1, mem_wdata=captured data, done=1; next state IDLE. Store latency is 1 cycle after start.
  - Load: mem_ren=1. Next state is WB if MEM_LAT==1; otherwise WAIT with the counter loaded to MEM_LAT-2.
- WAIT:
  - All strobes 0. mem_addr holds the captured value.
  - Decrement the counter; go to WB when the counter is 0.
- WB (cycle T+1+MEM_LAT):
  - rf_write_en=1, rf_waddr=captured rd, rf_data=mem_rdata (combinational pass-through), done=1; next state IDLE.
  - The register file writes at the end of WB.
- Outside ACCESS and WB, rf_data=0 and mem_wdata=0, so the buses are quiet.
- Load to r0 is legal and overwrites the accumulator.
- start while busy=1, including the done cycle, is ignored: no queueing, no error. Control must re-assert start after busy falls.
- Back-to-back commands:
  - start in the cycle after done is accepted.
  - Best-case throughput is 1 store per 2 cycles and 1 load per (2+MEM_LAT) cycles.
- reset asserted mid-operation: next cycle is IDLE with all strobes 0. An in-flight load never writes the register file, and a store not yet in ACCESS is dropped.
- rf_write_en and mem_wen are never high in the same cycle.
- Address wrap: no bounds check. Address 8'hFF is passed through unchanged.

Optional Feature:
- Macro: LSU_STAT_EN.
- Defined:
  - Adds outputs ld_cnt[15:0] and st_cnt[15:0].
  - Each increments on the done cycle of its operation type.
  - Both saturate at 16'hFFFF and reset to 0 on reset.
- Undefined: the ports and counters are absent. Core timing is identical either way.

Decomposition:
- Package lsu_pkg:
  - lsu_state_t enum {IDLE, ACCESS, WAIT, WB}.
  - Localparam LAT_CW = 3 (counter width).
- Sub-module lsu_sat_ctr (16-bit saturating counter with inc/reset), instantiated twice only under LSU_STAT_EN.
- The FSM and datapath stay in lsu_wb.

Test Plan:
- Reset, then idle 3 cycles -> busy=0, done=0, mem_ren=0, mem_wen=0, rf_write_en=0, mem_addr=0.
- Store (MEM_LAT=1): start, is_store=1, addr_in=8'h20, st_data=8'hA5 -> next cycle mem_wen=1, mem_addr=8'h20, mem_wdata=8'hA5, done=1; busy=0 the cycle after.
- Load (MEM_LAT=3): start, is_store=0, rd=4'd5, addr_in=8'h20; memory returns 8'hA5 -> mem_ren in cycle T+1, then 2 WAIT cycles; in cycle T+4 rf_write_en=1, rf_waddr=5, rf_data=8'hA5, done=1.
- start pulsed every cycle during a MEM_LAT=2 load -> only the first command executes; the next command is accepted in the cycle after done.
- reset asserted in the WAIT cycle of a MEM_LAT=3 load -> rf_write_en stays 0 throughout, busy=0 next cycle, and a new start afterwards behaves as in a fresh load.
- LSU_STAT_EN defined: 2 loads + 3 stores -> ld_cnt=2, st_cnt=3. Preload st_cnt to 16'hFFFF via force, issue a store -> st_cnt stays 16'hFFFF.
